// File: rtl/dma_sched.sv
// dma_sched: round-robin descriptor scheduler in front of a single DMA engine.
// Requesters hand descriptors over a valid/ready port into an in-order FIFO;
// a five-state FSM pops one descriptor at a time, checks MMU residency,
// starts the engine, waits for completion and reports a completion record.
//
// Handshake: a descriptor transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot or zero, may depend on
// req_valid (it is the arbiter grant), and is zero whenever the FIFO is full
// or rst is high. A requester holds its descriptor stable until it transfers.
//
// Optional feature: define DMA_SCHED_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles (completion status TIMEOUT). Without it, WAIT lasts
// until dma_done.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 CHECK, 2 ISSUE, 3 WAIT, 4 COMPLETE.
module dma_sched #(
    parameter int NUM_REQ        = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*64-1:0]       req_src,
    input  logic [NUM_REQ*64-1:0]       req_dst,
    input  logic [NUM_REQ*32-1:0]       req_len,
    output logic                        dma_start,
    output logic [63:0]                 dma_src,
    output logic [63:0]                 dma_dst,
    output logic [31:0]                 dma_len,
    input  logic                        src_resident,
    input  logic                        dst_resident,
    input  logic                        dma_done,
    output logic                        cmp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  cmp_id,
    output logic [1:0]                  cmp_status,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [2:0]                  dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_FAULT = 2'b01;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        ISSUE    = 3'd2,
        WAIT     = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    state_t state, state_d;
    logic [1:0] status_q, status_d;
    logic [IDW-1:0] act_id;

    // Descriptor FIFO storage and pointers.
    logic [63:0]    f_src [FIFO_DEPTH];
    logic [63:0]    f_dst [FIFO_DEPTH];
    logic [31:0]    f_len [FIFO_DEPTH];
    logic [IDW-1:0] f_id  [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop;

    // Arbiter.
    logic [IDW-1:0] rr_ptr, grant_idx;
    logic           grant_found;
    logic [63:0]    g_src, g_dst;
    logic [31:0]    g_len;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = |(req_valid & req_ready);
    assign pop   = (state == IDLE) && !empty;

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin : arb
        logic [IDW:0]   idx_w;
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_w       = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NUM_REQ)) idx_w = idx_w - (IDW+1)'(NUM_REQ);
            idx = idx_w[IDW-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Select the granted requester's descriptor fields.
    always_comb begin
        g_src = '0;
        g_dst = '0;
        g_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                g_src = req_src[i*64 +: 64];
                g_dst = req_dst[i*64 +: 64];
                g_len = req_len[i*32 +: 32];
            end
        end
    end

    // Ready is the grant, suppressed while full or in reset.
    always_comb begin
        req_ready = '0;
        if (!rst && !full && grant_found) req_ready[grant_idx] = 1'b1;
    end

    // FIFO entry write; storage needs no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            f_src[wr_ptr] <= g_src;
            f_dst[wr_ptr] <= g_dst;
            f_len[wr_ptr] <= g_len;
            f_id[wr_ptr]  <= grant_idx;
        end
    end

    // FIFO pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    logic [TW-1:0] to_cnt;

    // WAIT-cycle counter: zeroed in ISSUE so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst)                 to_cnt <= '0;
        else if (state == ISSUE) to_cnt <= '0;
        else if (state == WAIT)  to_cnt <= to_cnt + 1'b1;
    end
`else
    // The limit has no effect when the timeout is not compiled in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state and completion status.
    always_comb begin
        state_d  = state;
        status_d = status_q;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_d  = CHECK;
                    status_d = ST_OK;
                end
            end
            CHECK: begin
                if (!src_resident || !dst_resident) begin
                    state_d  = COMPLETE;
                    status_d = ST_FAULT;
                end else if (dma_len == '0) begin
                    state_d  = COMPLETE;
                    status_d = ST_OK;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (dma_done) begin
                    state_d  = COMPLETE;
                    status_d = ST_OK;
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = COMPLETE;
                    status_d = ST_TIMEOUT;
                end
`endif
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register and active descriptor, loaded on the IDLE pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            status_q <= ST_OK;
            act_id   <= '0;
            dma_src  <= '0;
            dma_dst  <= '0;
            dma_len  <= '0;
        end else begin
            state    <= state_d;
            status_q <= status_d;
            if (pop) begin
                dma_src <= f_src[rd_ptr];
                dma_dst <= f_dst[rd_ptr];
                dma_len <= f_len[rd_ptr];
                act_id  <= f_id[rd_ptr];
            end
        end
    end

    assign dma_start  = (state == ISSUE);
    assign cmp_valid  = (state == COMPLETE);
    assign cmp_id     = act_id;
    assign cmp_status = status_q;
    assign busy       = (state != IDLE);
    assign fifo_count = count;
    assign dbg_state  = state;

endmodule
